// File: rtl/servo_pkg.sv
// Shared types and helpers for the pan/tilt servo PWM generator.
package servo_pkg;
    localparam int US_W        = 11;
    localparam int FRAME_CNT_W = 15;

    typedef logic [US_W-1:0] us_t;

    typedef struct packed {
        us_t pan;
        us_t tilt;
    } servo_cmd_t;

    function automatic us_t clamp_us(us_t v, us_t lo, us_t hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction
endpackage

// File: rtl/servo_pwm_gen_if.sv
// Command handshake between the coordinate transform and the servo PWM generator.
interface servo_pwm_gen_if;
    servo_pkg::us_t pan_us;
    servo_pkg::us_t tilt_us;
    logic           cmd_valid;
    logic           cmd_ready;

    modport master (output pan_us, output tilt_us, output cmd_valid, input cmd_ready);
    modport slave  (input pan_us, input tilt_us, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/servo_pwm_channel.sv
// One servo channel: active width register, frame-boundary load and PWM compare.
// Optional SLEW_LIMIT_EN adds a target register and limits width change per frame.
module servo_pwm_channel import servo_pkg::*; #(
    parameter int CENTER_US    = 1500
`ifdef SLEW_LIMIT_EN
    ,
    parameter int SLEW_STEP_US = 10
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FRAME_CNT_W-1:0] i_frame_cnt,
    input  logic                   i_boundary,
    input  logic                   i_pend_vld,
    input  us_t                    i_width,
    output logic                   o_pwm
);
    us_t r_active;

`ifdef SLEW_LIMIT_EN
    localparam us_t STEP = us_t'(SLEW_STEP_US);
    us_t r_target;
    us_t w_tgt;
    us_t w_next;

    // A freshly loaded target takes part in the same boundary's step.
    always_comb begin
        w_tgt  = i_pend_vld ? i_width : r_target;
        w_next = w_tgt;
        if (w_tgt > r_active && (w_tgt - r_active) > STEP)
            w_next = r_active + STEP;
        else if (w_tgt < r_active && (r_active - w_tgt) > STEP)
            w_next = r_active - STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= us_t'(CENTER_US);
            r_active <= us_t'(CENTER_US);
        end else if (i_boundary) begin
            r_target <= w_tgt;
            r_active <= w_next;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_active <= us_t'(CENTER_US);
        else if (i_boundary && i_pend_vld)
            r_active <= i_width;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_pwm <= 1'b0;
        else        o_pwm <= (i_frame_cnt < {{(FRAME_CNT_W-US_W){1'b0}}, r_active});
    end
endmodule

// File: rtl/servo_pwm_gen.sv
// Dual 50 Hz hobby-servo PWM generator with clamped, frame-synchronous command updates.
// Define SLEW_LIMIT_EN to rate-limit width changes per frame.
module servo_pwm_gen import servo_pkg::*; #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int FRAME_US     = 20000,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000,
    parameter int CENTER_US    = 1500,
    parameter int SLEW_STEP_US = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    servo_pwm_gen_if.slave   cmd_if,
    output logic             pwm_pan,
    output logic             pwm_tilt,
    output logic             frame_start
);
    localparam int  DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int  PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam us_t LO    = us_t'(MIN_US);
    localparam us_t HI    = us_t'(MAX_US);

    if (CLK_FREQ_HZ % 1_000_000 != 0 || MIN_US > MAX_US || SLEW_STEP_US < 1) begin : g_bad_cfg
        $error("servo_pwm_gen: invalid parameter set");
    end

    logic [PRE_W-1:0]       r_pre;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    servo_cmd_t             r_pend;
    logic                   r_pend_full;
    logic                   r_frame_start;
    logic                   w_us_tick;
    logic                   w_boundary;
    logic                   w_accept;
    servo_cmd_t             w_clamped;

    assign w_us_tick  = (r_pre == PRE_W'(DIV - 1));
    assign w_boundary = w_us_tick && (r_frame_cnt == FRAME_CNT_W'(FRAME_US - 1));
    assign w_accept   = cmd_if.cmd_valid && !r_pend_full;
    assign w_clamped  = '{pan: clamp_us(cmd_if.pan_us, LO, HI), tilt: clamp_us(cmd_if.tilt_us, LO, HI)};

    assign cmd_if.cmd_ready = !r_pend_full;
    assign frame_start      = r_frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre         <= '0;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pre         <= w_us_tick ? '0 : r_pre + 1'b1;
            r_frame_start <= w_boundary;
            if (w_us_tick)
                r_frame_cnt <= w_boundary ? '0 : r_frame_cnt + 1'b1;
        end
    end

    // Accept only happens with pending empty, so an accept on a boundary cycle
    // simply waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend      <= w_clamped;
            r_pend_full <= 1'b1;
        end else if (w_boundary) begin
            r_pend_full <= 1'b0;
        end
    end

    servo_pwm_channel #(
        .CENTER_US    (CENTER_US)
`ifdef SLEW_LIMIT_EN
        ,
        .SLEW_STEP_US (SLEW_STEP_US)
`endif
    ) u_pan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame_cnt (r_frame_cnt),
        .i_boundary  (w_boundary),
        .i_pend_vld  (r_pend_full),
        .i_width     (r_pend.pan),
        .o_pwm       (pwm_pan)
    );

    servo_pwm_channel #(
        .CENTER_US    (CENTER_US)
`ifdef SLEW_LIMIT_EN
        ,
        .SLEW_STEP_US (SLEW_STEP_US)
`endif
    ) u_tilt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame_cnt (r_frame_cnt),
        .i_boundary  (w_boundary),
        .i_pend_vld  (r_pend_full),
        .i_width     (r_pend.tilt),
        .o_pwm       (pwm_tilt)
    );
endmodule
